// File: rtl/ahb_lite_master_pkg.sv
// Shared AHB-Lite encodings, master state enumeration and the command alignment rule.
package ahb_lite_master_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } state_t;

  // Unsupported sizes (above word) are treated as misaligned.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] lsb);
    return ((size == 3'd1) && lsb[0]) ||
           ((size == 3'd2) && (lsb != 2'b00)) ||
           (size > 3'd2);
  endfunction

endpackage

// File: rtl/ahb_lite_master.sv
// Single-outstanding AHB-Lite master: one command in, one SINGLE transfer on the bus,
// one response pulse out, with misalignment rejection and a data-phase stall timeout.
module ahb_lite_master
  import ahb_lite_master_pkg::*;
#(
  parameter int unsigned AWIDTH  = 10,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              HCLK,
  input  logic              HRESETN,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_WRITE,
  input  logic [AWIDTH-1:0] CMD_ADDR,
  input  logic [31:0]       CMD_WDATA,
  input  logic [2:0]        CMD_SIZE,
  output logic              RSP_VALID,
  output logic [31:0]       RSP_RDATA,
  output logic              RSP_ERROR,
  output logic              RSP_TIMEOUT,
  output logic [AWIDTH-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic              HMASTLOCK,
  output logic [3:0]        HPROT,
  output logic [31:0]       HWDATA,
  input  logic [31:0]       HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                cmd_ready_d;
  logic [1:0]          htrans_d;
  logic [AWIDTH-1:0]   haddr_d;
  logic                hwrite_d;
  logic [2:0]          hsize_d;
  logic [DATA_W-1:0]   hwdata_d;
  logic                rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_d;
  logic                rsp_error_d;
  logic                rsp_timeout_d;

  assign HBURST    = HBURST_SINGLE;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = HPROT_DEFAULT;

  // Next state plus next values of every registered output.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wdata_d       = wdata_q;
    haddr_d       = HADDR;
    hwrite_d      = HWRITE;
    hsize_d       = HSIZE;
    rsp_rdata_d   = RSP_RDATA;
    rsp_error_d   = RSP_ERROR;
    rsp_timeout_d = RSP_TIMEOUT;
    cnt_inc       = cnt_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (CMD_VALID && CMD_READY) begin
          haddr_d  = CMD_ADDR;
          hwrite_d = CMD_WRITE;
          hsize_d  = CMD_SIZE;
          wdata_d  = CMD_WDATA;
          if (is_misaligned(CMD_SIZE, CMD_ADDR[1:0])) begin
            state_d       = ST_RESP;
            rsp_rdata_d   = '0;
            rsp_error_d   = 1'b1;
            rsp_timeout_d = 1'b0;
          end else begin
            state_d = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (HREADY) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end
      end
      ST_DATA: begin
        if (HREADY) begin
          cnt_d         = '0;
          state_d       = ST_RESP;
          rsp_rdata_d   = (HRESP || HWRITE) ? '0 : HRDATA;
          rsp_error_d   = HRESP;
          rsp_timeout_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
          // Stall budget exhausted: give up on the slave.
          if (cnt_inc == CNT_W'(TIMEOUT)) begin
            state_d       = ST_RESP;
            rsp_rdata_d   = '0;
            rsp_error_d   = 1'b1;
            rsp_timeout_d = 1'b1;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    htrans_d    = (state_d == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    hwdata_d    = ((state_d == ST_DATA) && hwrite_d) ? wdata_d : '0;
    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      wdata_q     <= '0;
      CMD_READY   <= 1'b0;
      HTRANS      <= HTRANS_IDLE;
      HADDR       <= '0;
      HWRITE      <= 1'b0;
      HSIZE       <= '0;
      HWDATA      <= '0;
      RSP_VALID   <= 1'b0;
      RSP_RDATA   <= '0;
      RSP_ERROR   <= 1'b0;
      RSP_TIMEOUT <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      CMD_READY   <= cmd_ready_d;
      HTRANS      <= htrans_d;
      HADDR       <= haddr_d;
      HWRITE      <= hwrite_d;
      HSIZE       <= hsize_d;
      HWDATA      <= hwdata_d;
      RSP_VALID   <= rsp_valid_d;
      RSP_RDATA   <= rsp_rdata_d;
      RSP_ERROR   <= rsp_error_d;
      RSP_TIMEOUT <= rsp_timeout_d;
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master: behavioural slave per transaction, expected responses queued
// at command issue and compared when RSP_VALID fires.
module tb_ahb_lite_master;

  localparam int unsigned AW  = 10;
  localparam int unsigned TMO = 4;

  logic          HCLK, HRESETN;
  logic          CMD_VALID, CMD_READY, CMD_WRITE;
  logic [AW-1:0] CMD_ADDR;
  logic [31:0]   CMD_WDATA;
  logic [2:0]    CMD_SIZE;
  logic          RSP_VALID, RSP_ERROR, RSP_TIMEOUT;
  logic [31:0]   RSP_RDATA;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE, HMASTLOCK;
  logic [2:0]    HSIZE, HBURST;
  logic [3:0]    HPROT;
  logic [31:0]   HWDATA, HRDATA;
  logic          HREADY, HRESP;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_bad = 0;

  ahb_lite_master #(.AWIDTH(AW), .TIMEOUT(TMO)) dut (
    .HCLK(HCLK), .HRESETN(HRESETN),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_SIZE(CMD_SIZE),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERROR(RSP_ERROR),
    .RSP_TIMEOUT(RSP_TIMEOUT),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Issue one command and play the slave; stuck=1 holds HREADY low forever in the data phase.
  task automatic run_txn(input logic wr, input logic [AW-1:0] a, input logic [31:0] wd,
                         input logic [2:0] sz, input int waits, input bit err,
                         input bit stuck, input logic [31:0] rd);
    exp_t e, g;
    bit   mis, done;
    int   lat, k;
    logic [1:0] lsb;
    lsb = a[1:0];
    mis = (sz == 3'd1 && lsb[0]) || (sz == 3'd2 && lsb != 2'b00) || (sz > 3'd2);
    e.err   = mis || err || stuck;
    e.tmo   = stuck;
    e.rdata = (wr || e.err) ? 32'h0 : rd;
    e.lat   = mis ? 1 : (stuck ? 2 + int'(TMO) : 3 + waits);
    sb.push_back(e);

    chk("cmd_ready_idle", 32'(CMD_READY), 32'h1);
    CMD_VALID = 1'b1; CMD_WRITE = wr; CMD_ADDR = a; CMD_WDATA = wd; CMD_SIZE = sz;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'hA5A5_5A5A;
    @(posedge HCLK);
    @(negedge HCLK);
    CMD_VALID = 1'b0;
    lat = 1;
    if (mis) begin
      chk("mis_no_nonseq", 32'(HTRANS), 32'h0);
    end else begin
      chk("addr_htrans", 32'(HTRANS), 32'h2);
      chk("addr_haddr", 32'(HADDR), 32'(a));
      chk("addr_hwrite", 32'(HWRITE), 32'(wr));
      chk("addr_hsize", 32'(HSIZE), 32'(sz));
      chk("addr_ready_low", 32'(CMD_READY), 32'h0);
    end

    done = 1'b0;
    while (!done && lat < 40) begin
      if (RSP_VALID) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 32'h1, 32'h0);
        end else begin
          g = sb.pop_front();
          chk("rsp_rdata", RSP_RDATA, g.rdata);
          chk("rsp_error", 32'(RSP_ERROR), 32'(g.err));
          chk("rsp_timeout", 32'(RSP_TIMEOUT), 32'(g.tmo));
          chk("rsp_latency", 32'(lat), 32'(g.lat));
        end
        chk("resp_htrans", 32'(HTRANS), 32'h0);
        done = 1'b1;
      end else begin
        if (lat >= 2) begin
          chk("data_htrans", 32'(HTRANS), 32'h0);
          if (lat == 2) chk("data_hwdata", HWDATA, wr ? wd : 32'h0);
          k = lat - 2;
          HREADY = stuck ? 1'b0 : (k >= waits);
          HRESP  = err && (k >= waits - 1);
          HRDATA = (k >= waits) ? rd : 32'hBAD0_0000 | 32'(k);
        end
        @(negedge HCLK);
        lat++;
      end
    end
    if (!done) chk("rsp_wait_bound", 32'h0, 32'h1);
    HREADY = 1'b1; HRESP = 1'b0;
    @(negedge HCLK);
    chk("rsp_one_cycle", 32'(RSP_VALID), 32'h0);
    chk("rsp_error_hold", 32'(RSP_ERROR), 32'(e.err));
    chk("ready_again", 32'(CMD_READY), 32'h1);
  endtask

  initial begin
    HRESETN = 1'b0; CMD_VALID = 1'b0; CMD_WRITE = 1'b0; CMD_ADDR = '0;
    CMD_WDATA = '0; CMD_SIZE = '0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    repeat (3) @(negedge HCLK);
    chk("rst_ready", 32'(CMD_READY), 32'h0);
    chk("rst_htrans", 32'(HTRANS), 32'h0);
    chk("rst_rsp_valid", 32'(RSP_VALID), 32'h0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("hburst", 32'(HBURST), 32'h0);
    chk("hmastlock", 32'(HMASTLOCK), 32'h0);
    chk("hprot", 32'(HPROT), 32'h3);
    HRESETN = 1'b1;
    @(negedge HCLK);
    chk("ready_after_rst", 32'(CMD_READY), 32'h1);

    run_txn(1'b1, 10'h040, 32'hDEAD_BEEF, 3'd2, 0, 1'b0, 1'b0, 32'h0);
    run_txn(1'b0, 10'h100, 32'h0, 3'd2, 0, 1'b0, 1'b0, 32'hCAFE_F00D);
    run_txn(1'b0, 10'h100, 32'h0, 3'd2, 3, 1'b0, 1'b0, 32'h1234_5678);
    run_txn(1'b0, 10'h080, 32'h0, 3'd2, 1, 1'b1, 1'b0, 32'h5555_AAAA);
    run_txn(1'b0, 10'h003, 32'h0, 3'd1, 0, 1'b0, 1'b0, 32'h0);
    run_txn(1'b0, 10'h200, 32'h0, 3'd2, 0, 1'b0, 1'b1, 32'h0);
    run_txn(1'b1, 10'h003, 32'h0000_00AB, 3'd0, 2, 1'b0, 1'b0, 32'h0);
    run_txn(1'b0, 10'h000, 32'h0, 3'd3, 0, 1'b0, 1'b0, 32'h0);
    run_txn(1'b1, 10'h042, 32'h0000_1234, 3'd1, 0, 1'b0, 1'b0, 32'h0);
    run_txn(1'b0, 10'h002, 32'h0, 3'd2, 0, 1'b0, 1'b0, 32'h0);

    // Reset during a data-phase stall.
    CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = 10'h100; CMD_WDATA = 32'h0BAD_F00D;
    CMD_SIZE = 3'd2;
    @(posedge HCLK);
    @(negedge HCLK);
    CMD_VALID = 1'b0;
    @(negedge HCLK);
    HREADY = 1'b0;
    chk("pre_rst_hwdata", HWDATA, 32'h0BAD_F00D);
    @(negedge HCLK);
    #2 HRESETN = 1'b0;
    #1;
    chk("midrst_htrans", 32'(HTRANS), 32'h0);
    chk("midrst_haddr", 32'(HADDR), 32'h0);
    chk("midrst_hwrite", 32'(HWRITE), 32'h0);
    chk("midrst_hwdata", HWDATA, 32'h0);
    chk("midrst_ready", 32'(CMD_READY), 32'h0);
    chk("midrst_rsp_valid", 32'(RSP_VALID), 32'h0);
    @(negedge HCLK);
    HRESETN = 1'b1; HREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge HCLK);
      chk("postrst_no_rsp", 32'(RSP_VALID), 32'h0);
      if (i == 0) chk("postrst_ready", 32'(CMD_READY), 32'h1);
    end
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/ahb_lite_master.md
AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

Interface
REQ-001 SHALL have parameter AWIDTH, default 10: HADDR/CMD_ADDR width.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum count of HREADY-low cycles in the data phase; range 1..65535.
REQ-003 SHALL have ports:
- HCLK, in, 1: the single clock.
- HRESETN, in, 1: asynchronous, active-low reset.
- CMD_VALID, in, 1: command request.
- CMD_READY, out, 1: command accepted when high together with CMD_VALID.
- CMD_WRITE, in, 1: 1 = write, 0 = read.
- CMD_ADDR, in, AWIDTH: byte address.
- CMD_WDATA, in, 32: write data, already lane-positioned.
- CMD_SIZE, in, 3: 0 = byte, 1 = half, 2 = word.
- RSP_VALID, out, 1: one-cycle completion pulse.
- RSP_RDATA, out, 32: captured HRDATA; 0 for writes.
- RSP_ERROR, out, 1: HRESP error, misalignment or timeout.
- RSP_TIMEOUT, out, 1: the error was caused by timeout.
- HADDR, out, AWIDTH; HTRANS, out, 2; HWRITE, out, 1; HSIZE, out, 3.
- HBURST, out, 3: constant SINGLE (000).
- HMASTLOCK, out, 1: constant 0.
- HPROT, out, 4: constant 0011.
- HWDATA, out, 32.
- HRDATA, in, 32; HREADY, in, 1; HRESP, in, 1.

Function
REQ-004 SHALL implement the states IDLE, ADDR, DATA and RESP.
REQ-005 SHALL assert CMD_READY only in IDLE; a handshake latches CMD_WRITE, CMD_ADDR, CMD_WDATA and CMD_SIZE, then moves to ADDR.
REQ-006 SHALL check alignment at the handshake: size 1 with addr[0]=1, size 2 with addr[1:0]!=0, or size >2 goes straight to RESP with RSP_ERROR=1; no bus transfer is issued.
REQ-007 In ADDR, SHALL drive HTRANS=NONSEQ (10) with the latched HADDR, HWRITE and HSIZE; SHALL hold these while HREADY=0; moves to DATA on the first cycle HREADY=1.
REQ-008 In DATA, SHALL drive HTRANS=IDLE (00) and drive HWDATA=latched data for writes; HWDATA is 0 otherwise.
REQ-009 In DATA, when HREADY=1 and HRESP=0, SHALL capture HRDATA for reads (0 for writes), clear the error flags and move to RESP.
REQ-010 In DATA, when HRESP=1 (either cycle of the two-cycle ERROR response), SHALL set the error flag; on the HREADY=1 cycle it moves to RESP with RSP_ERROR=1 and RSP_RDATA=0.
REQ-011 In DATA, SHALL count consecutive HREADY=0 cycles; when the count reaches TIMEOUT, it moves to RESP with RSP_ERROR=1 and RSP_TIMEOUT=1.
REQ-012 In RESP, SHALL assert RSP_VALID for exactly one cycle, then return to IDLE; RSP_* data outputs hold until the next RSP_VALID.
REQ-013 With HREADY always 1, accept at edge N SHALL give the address phase in cycle N+1, the data phase in N+2 and RSP_VALID in N+3.
REQ-014 SHALL drive HTRANS=IDLE in every state except ADDR; at most one transfer is outstanding.
REQ-015 The timeout counter SHALL be 16 bits and clear on entry to DATA; HREADY=1 in any cycle resets it to 0.

Reset
REQ-016 HRESETN low SHALL asynchronously force:
- state IDLE;
- CMD_READY=0 during reset, 1 in the first cycle after release;
- HTRANS=00, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0;
- RSP_VALID=0, RSP_RDATA=0, RSP_ERROR=0, RSP_TIMEOUT=0;
- counter 0.
REQ-017 Reset asserted mid-transfer SHALL abandon the transfer with no RSP_VALID.

Structure
REQ-018 A shared package SHALL hold the HTRANS and HBURST encodings, the HPROT default and the state enumeration.
REQ-019 SHALL be a single module with no sub-modules.

Verification
REQ-020 Word write to 0x040 with data 0xDEADBEEF, HREADY=1 -> NONSEQ at N+1 with HADDR=0x040, HWDATA=0xDEADBEEF at N+2, RSP_VALID at N+3 with RSP_ERROR=0.
REQ-021 Word read of 0x100, slave holds HREADY=0 for 3 data cycles, then returns 0x12345678 -> RSP_RDATA=0x12345678, RSP_VALID 3 cycles later than the no-wait case.
REQ-022 Two-cycle ERROR response on a read -> RSP_ERROR=1, RSP_TIMEOUT=0, RSP_RDATA=0, HTRANS=00 throughout.
REQ-023 Half-word read at 0x003 -> no NONSEQ issued, RSP_VALID at N+1 with RSP_ERROR=1.
REQ-024 TIMEOUT=4, HREADY stuck at 0 in the data phase -> RSP_VALID after 4 stall cycles with RSP_ERROR=1 and RSP_TIMEOUT=1.
REQ-025 HRESETN pulsed low during a DATA stall -> all outputs at reset values immediately, no RSP_VALID, CMD_READY=1 in the first cycle after release.
